// File: rtl/hs_flow_motion_stats.sv
// Per-pixel L1 optical-flow magnitude, motion flag and per-frame motion statistics.
// Optional: define HS_FLOW_STATS_SUM_EN to add io_mag_sum, the saturating per-frame sum of io_mag_out.
module hs_flow_motion_stats #(
  parameter int FP_WIDTH     = 26,
  parameter int IMAGE_WIDTH  = 584,
  parameter int IMAGE_HEIGHT = 388,
  parameter int MAG_SHIFT    = 12,
  parameter int CNT_WIDTH    = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_frame_sync_in,
  input  logic [FP_WIDTH-1:0]  io_data_in_u,
  input  logic [FP_WIDTH-1:0]  io_data_in_v,
  input  logic [FP_WIDTH-1:0]  io_threshold,
  output logic                 io_frame_sync_out,
  output logic [7:0]           io_mag_out,
  output logic                 io_motion_flag,
  output logic                 io_stats_valid,
  output logic [CNT_WIDTH-1:0] io_motion_count,
  output logic [7:0]           io_max_mag,
  output logic                 io_frame_error
`ifdef HS_FLOW_STATS_SUM_EN
  ,
  output logic [31:0]          io_mag_sum
`endif
);

  localparam logic [CNT_WIDTH-1:0] IMAGE_SIZE = CNT_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam logic [FP_WIDTH-2:0]  ABS_MAX    = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // The most negative input has no positive twin, so it clamps to the largest positive value.
  function automatic logic [FP_WIDTH-2:0] abs_sat(input logic [FP_WIDTH-1:0] x);
    if (!x[FP_WIDTH-1])
      abs_sat = x[FP_WIDTH-2:0];
    else if (x[FP_WIDTH-2:0] == '0)
      abs_sat = ABS_MAX;
    else
      abs_sat = ~x[FP_WIDTH-2:0] + (FP_WIDTH-1)'(1);
  endfunction

  logic [FP_WIDTH-2:0] abs_u, abs_v;
  logic                sync_s1;
  logic [FP_WIDTH:0]   mag_wide;
  logic [FP_WIDTH-1:0] mag, mag_shifted;
  logic [7:0]          mag_sat8;

  assign mag_wide    = {2'b00, abs_u} + {2'b00, abs_v};
  assign mag         = mag_wide[FP_WIDTH] ? '1 : mag_wide[FP_WIDTH-1:0];
  assign mag_shifted = mag >> MAG_SHIFT;
  assign mag_sat8    = (|mag_shifted[FP_WIDTH-1:8]) ? 8'hFF : mag_shifted[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      abs_u             <= '0;
      abs_v             <= '0;
      sync_s1           <= 1'b0;
      io_frame_sync_out <= 1'b0;
      io_mag_out        <= '0;
      io_motion_flag    <= 1'b0;
    end else begin
      abs_u             <= abs_sat(io_data_in_u);
      abs_v             <= abs_sat(io_data_in_v);
      sync_s1           <= io_frame_sync_in;
      io_frame_sync_out <= sync_s1;
      io_mag_out        <= mag_sat8;
      io_motion_flag    <= (mag > io_threshold);
    end
  end

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] pix_cnt, acc_cnt, pix_cnt_next, acc_cnt_next;
  logic [7:0]           acc_max, acc_max_next;
  logic [CNT_WIDTH-1:0] pix_n, cnt_n, motion_count_next;
  logic [7:0]           max_n, max_mag_next;
  logic                 stats_valid_next, frame_error_next;

  // A sync pixel always seeds a fresh frame; otherwise the current pixel extends the open one.
  assign pix_n = io_frame_sync_out ? CNT_WIDTH'(1) : pix_cnt + CNT_WIDTH'(1);
  assign cnt_n = (io_frame_sync_out ? '0 : acc_cnt) + CNT_WIDTH'(io_motion_flag);
  assign max_n = (io_frame_sync_out || io_mag_out > acc_max) ? io_mag_out : acc_max;

`ifdef HS_FLOW_STATS_SUM_EN
  logic [31:0] acc_sum, acc_sum_next, mag_sum_next, sum_n;
  logic [32:0] sum_wide;
  assign sum_wide = {1'b0, (io_frame_sync_out ? 32'd0 : acc_sum)} + 33'(io_mag_out);
  assign sum_n    = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`endif

  always_comb begin
    state_next        = state;
    pix_cnt_next      = pix_cnt;
    acc_cnt_next      = acc_cnt;
    acc_max_next      = acc_max;
    stats_valid_next  = 1'b0;
    frame_error_next  = io_frame_sync_out && (state == ACTIVE);
    motion_count_next = io_motion_count;
    max_mag_next      = io_max_mag;
`ifdef HS_FLOW_STATS_SUM_EN
    acc_sum_next      = acc_sum;
    mag_sum_next      = io_mag_sum;
`endif
    if (io_frame_sync_out || state == ACTIVE) begin
      if (pix_n == IMAGE_SIZE) begin
        state_next        = IDLE;
        stats_valid_next  = 1'b1;
        motion_count_next = cnt_n;
        max_mag_next      = max_n;
`ifdef HS_FLOW_STATS_SUM_EN
        mag_sum_next      = sum_n;
`endif
      end else begin
        state_next   = ACTIVE;
        pix_cnt_next = pix_n;
        acc_cnt_next = cnt_n;
        acc_max_next = max_n;
`ifdef HS_FLOW_STATS_SUM_EN
        acc_sum_next = sum_n;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      acc_cnt         <= '0;
      acc_max         <= '0;
      io_stats_valid  <= 1'b0;
      io_frame_error  <= 1'b0;
      io_motion_count <= '0;
      io_max_mag      <= '0;
`ifdef HS_FLOW_STATS_SUM_EN
      acc_sum         <= '0;
      io_mag_sum      <= '0;
`endif
    end else begin
      state           <= state_next;
      pix_cnt         <= pix_cnt_next;
      acc_cnt         <= acc_cnt_next;
      acc_max         <= acc_max_next;
      io_stats_valid  <= stats_valid_next;
      io_frame_error  <= frame_error_next;
      io_motion_count <= motion_count_next;
      io_max_mag      <= max_mag_next;
`ifdef HS_FLOW_STATS_SUM_EN
      acc_sum         <= acc_sum_next;
      io_mag_sum      <= mag_sum_next;
`endif
    end
  end

endmodule
